// File: rtl/svpwm_modulator_if.sv
// Command/status bundle between the inverse Park stage and the SVPWM modulator.
// The master side drives the alpha/beta command and start strobe, and the slave side returns duties and gates.
interface svpwm_modulator_if #(
    parameter int D_WIDTH   = 32,
    parameter int CNT_WIDTH = 16
);
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [CNT_WIDTH-1:0]      duty_a;
    logic [CNT_WIDTH-1:0]      duty_b;
    logic [CNT_WIDTH-1:0]      duty_c;
    logic                      pwm_a;
    logic                      pwm_b;
    logic                      pwm_c;
    logic                      pwm_sync;

    modport master (
        output alpha, beta, start,
        input  busy, done, duty_a, duty_b, duty_c, pwm_a, pwm_b, pwm_c, pwm_sync
    );

    modport slave (
        input  alpha, beta, start,
        output busy, done, duty_a, duty_b, duty_c, pwm_a, pwm_b, pwm_c, pwm_sync
    );
endinterface

// File: rtl/svpwm_modulator.sv
// Inverse Clarke, min-max zero-sequence injection and duty scaling, feeding a
// center-aligned three-phase PWM with duties double-buffered at carrier zero.
module svpwm_modulator #(
    parameter int D_WIDTH   = 32,
    parameter int Q_BITS    = 10,
    parameter int CNT_WIDTH = 16,
    parameter int PWM_HALF  = 1000,
    parameter int SQRT3_2   = 887
) (
    input  logic               clk,
    input  logic               rst,
    svpwm_modulator_if.slave   bus_io
);
    localparam int PW = 2 * D_WIDTH;
    localparam int VW = D_WIDTH + 1;
    localparam int SW = VW + CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  ZERO_C  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]  ONE_C   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  HALF_C  = CNT_WIDTH'(PWM_HALF);
    localparam logic [CNT_WIDTH-1:0]  TOPM1_C = CNT_WIDTH'(PWM_HALF - 1);
    localparam logic [CNT_WIDTH-1:0]  MID_C   = CNT_WIDTH'(PWM_HALF / 2);
    localparam logic signed [PW-1:0]  K_S     = PW'(SQRT3_2);
    localparam logic signed [SW-1:0]  ZERO_S  = SW'(0);
    localparam logic signed [SW-1:0]  MID_S   = SW'(PWM_HALF / 2);
    localparam logic signed [SW-1:0]  HALF_S  = SW'(PWM_HALF);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLARKE = 2'd1, S_INJECT = 2'd2, S_SCALE = 2'd3} state_t;

    state_t state_q, state_d;
    logic signed [D_WIDTH-1:0] alpha_q, beta_q;
    logic signed [D_WIDTH-1:0] va_q, vb_q, vc_q, vb_d, vc_d;
    logic signed [VW-1:0]      wa_q, wb_q, wc_q, wa_d, wb_d, wc_d;
    logic signed [PW-1:0]      p_s, nh_s, sb_s;
    logic signed [D_WIDTH-1:0] mx_s, mn_s;
    logic signed [VW-1:0]      off_s;
    logic [CNT_WIDTH-1:0]      sh_a_q, sh_b_q, sh_c_q, act_a_q, act_b_q, act_c_q;
    logic [CNT_WIDTH-1:0]      act_a_s, act_b_s, act_c_s, cnt_q, cnt_d;
    logic                      dir_up_q, dir_up_d, sync_d;
    logic                      busy_q, done_q, pwm_a_q, pwm_b_q, pwm_c_q, sync_q;

    // Maps an injected phase voltage to a duty count, floor-rounded and saturated.
    function automatic logic [CNT_WIDTH-1:0] scale_duty(input logic signed [VW-1:0] v);
        logic signed [SW-1:0] prod_s;
        logic signed [SW-1:0] d_s;
        prod_s = SW'(v) * MID_S;
        d_s    = MID_S + (prod_s >>> Q_BITS);
        if (d_s < ZERO_S) begin
            scale_duty = ZERO_C;
        end else if (d_s > HALF_S) begin
            scale_duty = HALF_C;
        end else begin
            scale_duty = d_s[CNT_WIDTH-1:0];
        end
    endfunction

    // Sequencer next state: one cycle per stage, start ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus_io.start ? S_CLARKE : S_IDLE;
            S_CLARKE: state_d = S_INJECT;
            S_INJECT: state_d = S_SCALE;
            S_SCALE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Inverse Clarke and min-max injection, both computed at double width before narrowing.
    always_comb begin
        p_s   = K_S * PW'(beta_q);
        nh_s  = (-PW'(alpha_q)) >>> 1;
        sb_s  = p_s >>> Q_BITS;
        vb_d  = D_WIDTH'(nh_s + sb_s);
        vc_d  = D_WIDTH'(nh_s - sb_s);
        mx_s  = (va_q > vb_q) ? va_q : vb_q;
        mx_s  = (mx_s > vc_q) ? mx_s : vc_q;
        mn_s  = (va_q < vb_q) ? va_q : vb_q;
        mn_s  = (mn_s < vc_q) ? mn_s : vc_q;
        off_s = (VW'(mx_s) + VW'(mn_s)) >>> 1;
        wa_d  = VW'(va_q) - off_s;
        wb_d  = VW'(vb_q) - off_s;
        wc_d  = VW'(vc_q) - off_s;
    end

    // Carrier stepping and compare; at carrier zero the shadow value is already the one in force.
    always_comb begin
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        if (dir_up_q) begin
            cnt_d    = cnt_q + ONE_C;
            dir_up_d = (cnt_q != TOPM1_C);
        end else begin
            cnt_d    = cnt_q - ONE_C;
            dir_up_d = (cnt_q == ONE_C);
        end
        sync_d  = (cnt_q == ZERO_C);
        act_a_s = sync_d ? sh_a_q : act_a_q;
        act_b_s = sync_d ? sh_b_q : act_b_q;
        act_c_s = sync_d ? sh_c_q : act_c_q;
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alpha_q <= '0;
            beta_q  <= '0;
            va_q    <= '0;
            vb_q    <= '0;
            vc_q    <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            wc_q    <= '0;
            sh_a_q  <= MID_C;
            sh_b_q  <= MID_C;
            sh_c_q  <= MID_C;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_SCALE);
            if (state_q == S_IDLE && bus_io.start) begin
                alpha_q <= bus_io.alpha;
                beta_q  <= bus_io.beta;
            end
            if (state_q == S_CLARKE) begin
                va_q <= alpha_q;
                vb_q <= vb_d;
                vc_q <= vc_d;
            end
            if (state_q == S_INJECT) begin
                wa_q <= wa_d;
                wb_q <= wb_d;
                wc_q <= wc_d;
            end
            if (state_q == S_SCALE) begin
                sh_a_q <= scale_duty(wa_q);
                sh_b_q <= scale_duty(wb_q);
                sh_c_q <= scale_duty(wc_q);
            end
        end
    end

    // Carrier, active duty buffers and registered gate outputs; full-scale duty forces the gate high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= ZERO_C;
            dir_up_q <= 1'b1;
            act_a_q  <= MID_C;
            act_b_q  <= MID_C;
            act_c_q  <= MID_C;
            pwm_a_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
            pwm_c_q  <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            act_a_q  <= act_a_s;
            act_b_q  <= act_b_s;
            act_c_q  <= act_c_s;
            pwm_a_q  <= (cnt_q < act_a_s) || (act_a_s >= HALF_C);
            pwm_b_q  <= (cnt_q < act_b_s) || (act_b_s >= HALF_C);
            pwm_c_q  <= (cnt_q < act_c_s) || (act_c_s >= HALF_C);
            sync_q   <= sync_d;
        end
    end

    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.duty_a   = sh_a_q;
    assign bus_io.duty_b   = sh_b_q;
    assign bus_io.duty_c   = sh_c_q;
    assign bus_io.pwm_a    = pwm_a_q;
    assign bus_io.pwm_b    = pwm_b_q;
    assign bus_io.pwm_c    = pwm_c_q;
    assign bus_io.pwm_sync = sync_q;
endmodule

// File: tb/tb_svpwm_modulator.sv
// Scoreboard bench for svpwm_modulator: expected duties are queued at each start
// and compared when done pulses; gate waveforms are checked against a carrier model.
module tb_svpwm_modulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svpwm_modulator_if ifc ();
    svpwm_modulator dut (.clk(clk), .rst(rst), .bus_io(ifc));

    typedef struct {int a; int b; int c;} exp_t;
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int model_duty(input real v);
        real d;
        d = 500.0 + $floor(v * 500.0 / 1024.0);
        if (d < 0.0) d = 0.0;
        if (d > 1000.0) d = 1000.0;
        return $rtoi(d);
    endfunction

    function automatic exp_t model(input int a, input int b);
        real va, vb, vc, mx, mn, off;
        exp_t e;
        va  = a;
        vb  = $floor(-a / 2.0) + $floor(887.0 * b / 1024.0);
        vc  = $floor(-a / 2.0) - $floor(887.0 * b / 1024.0);
        mx  = (va > vb) ? va : vb;
        mx  = (mx > vc) ? mx : vc;
        mn  = (va < vb) ? va : vb;
        mn  = (mn < vc) ? mn : vc;
        off = $floor((mx + mn) / 2.0);
        e.a = model_duty(va - off);
        e.b = model_duty(vb - off);
        e.c = model_duty(vc - off);
        return e;
    endfunction

    task automatic issue(input int a, input int b, input exp_t e);
        ifc.alpha = a;
        ifc.beta  = b;
        ifc.start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (ifc.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_period(output int ha, output int hb, output int hc, output bit ok);
        int n;
        ha = 0; hb = 0; hc = 0; n = 0;
        @(negedge clk);
        while (ifc.pwm_sync !== 1'b1 && n < 2100) begin
            @(negedge clk);
            n++;
        end
        ok = (ifc.pwm_sync === 1'b1);
        for (int i = 0; i < 2000; i++) begin
            if (i > 0) @(negedge clk);
            ha += int'(ifc.pwm_a);
            hb += int'(ifc.pwm_b);
            hc += int'(ifc.pwm_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
        checks++; if ({ifc.pwm_a, ifc.pwm_b, ifc.pwm_c, ifc.pwm_sync} !== 4'b0000) begin
            failures++; $display("FAIL reset_pwm: got %b expected 0000", {ifc.pwm_a, ifc.pwm_b, ifc.pwm_c, ifc.pwm_sync}); end
        checks++; if (ifc.duty_a !== 16'd500 || ifc.duty_b !== 16'd500 || ifc.duty_c !== 16'd500) begin
            failures++; $display("FAIL reset_duty: got %0d/%0d/%0d expected 500", ifc.duty_a, ifc.duty_b, ifc.duty_c); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifc.pwm_sync !== 1'b1 || ifc.pwm_a !== 1'b1) begin
            failures++; $display("FAIL first_sync: got sync=%b pwm_a=%b expected 1/1", ifc.pwm_sync, ifc.pwm_a); end
        @(negedge clk);
        checks++; if (ifc.pwm_sync !== 1'b0) begin failures++; $display("FAIL sync_pulse: got %b expected 0", ifc.pwm_sync); end
    endtask

    task automatic test_zero();
        int lat, ha, hb, hc;
        bit ok;
        exp_t e;
        issue(0, 0, '{500, 500, 500});
        wait_done(lat);
        checks++; if (ifc.done !== 1'b1 || lat != 4) begin failures++; $display("FAIL zero_latency: got %0d expected 4", lat); end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++; if (ifc.duty_a !== 16'(e.a)) begin failures++; $display("FAIL zero_duty_a: got %0d expected %0d", ifc.duty_a, e.a); end
            checks++; if (ifc.duty_b !== 16'(e.b)) begin failures++; $display("FAIL zero_duty_b: got %0d expected %0d", ifc.duty_b, e.b); end
            checks++; if (ifc.duty_c !== 16'(e.c)) begin failures++; $display("FAIL zero_duty_c: got %0d expected %0d", ifc.duty_c, e.c); end
        end
        @(negedge clk);
        checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL done_pulse: got %b expected 0", ifc.done); end
        count_period(ha, hb, hc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL zero_sync_timeout: got 0 expected 1"); end
        checks++; if (ha != 999 || hb != 999 || hc != 999) begin
            failures++; $display("FAIL zero_pwm_high: got %0d/%0d/%0d expected 999", ha, hb, hc); end
    endtask

    task automatic test_vectors();
        int lat, a, b;
        exp_t e, g;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin a = 512; b = 0; e = '{687, 312, 312}; end
            else if (i == 1) begin a = 0; b = 1024; e = '{500, 933, 66}; end
            else begin
                a = int'($urandom_range(4000)) - 2000;
                b = int'($urandom_range(4000)) - 2000;
                e = model(a, b);
            end
            issue(a, b, e);
            wait_done(lat);
            checks++;
            if (ifc.done !== 1'b1 || sb_q.size() == 0) begin
                failures++; $display("FAIL vec%0d_done: got timeout expected done", i);
            end else begin
                g = sb_q.pop_front();
                if (ifc.duty_a !== 16'(g.a) || ifc.duty_b !== 16'(g.b) || ifc.duty_c !== 16'(g.c)) begin
                    failures++;
                    $display("FAIL vec%0d_duty (a=%0d b=%0d): got %0d/%0d/%0d expected %0d/%0d/%0d",
                             i, a, b, ifc.duty_a, ifc.duty_b, ifc.duty_c, g.a, g.b, g.c);
                end
            end
        end
    endtask

    task automatic test_overmod();
        int lat, ha, hb, hc;
        bit ok;
        exp_t e;
        issue(4096, 0, '{1000, 0, 0});
        wait_done(lat);
        checks++;
        if (ifc.done !== 1'b1 || sb_q.size() == 0) begin
            failures++; $display("FAIL overmod_done: got timeout expected done");
        end else begin
            e = sb_q.pop_front();
            if (ifc.duty_a !== 16'(e.a) || ifc.duty_b !== 16'(e.b) || ifc.duty_c !== 16'(e.c)) begin
                failures++; $display("FAIL overmod_duty: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                     ifc.duty_a, ifc.duty_b, ifc.duty_c, e.a, e.b, e.c);
            end
        end
        count_period(ha, hb, hc, ok);
        checks++; if (!ok || ha != 2000 || hb != 0 || hc != 0) begin
            failures++; $display("FAIL overmod_pwm_high: got %0d/%0d/%0d expected 2000/0/0", ha, hb, hc); end
    endtask

    task automatic test_back_to_back();
        int dones;
        exp_t e;
        dones = 0;
        issue(0, 0, '{500, 500, 500});
        checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL busy_high: got %b expected 1", ifc.busy); end
        ifc.alpha = 512;
        ifc.start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 1) ifc.start = 1'b0;
            if (ifc.done === 1'b1) begin
                dones++;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (ifc.duty_a !== 16'(e.a)) begin failures++; $display("FAIL b2b_duty_a: got %0d expected %0d", ifc.duty_a, e.a); end
                end
            end
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_shadow_timing();
        int mcnt, mact, msh, bad, h1, h2, n, a_new;
        bit mup, expv;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (ifc.pwm_sync !== 1'b1 && n < 2100) begin @(negedge clk); n++; end
        checks++; if (ifc.pwm_sync !== 1'b1) begin failures++; $display("FAIL shadow_sync_timeout: got 0 expected 1"); end
        mcnt = 0; mup = 1'b1; mact = 500; msh = 500; bad = 0; h1 = 0; h2 = 0;
        e = model(512, 0);
        a_new = e.a;
        for (int i = 0; i < 4000; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (mup) begin mcnt++; if (mcnt == 1000) mup = 1'b0; end
                else begin mcnt--; if (mcnt == 0) mup = 1'b1; end
            end
            if (mcnt == 0) mact = msh;
            expv = (mcnt < mact) || (mact >= 1000);
            if (ifc.pwm_a !== expv || ifc.pwm_sync !== (mcnt == 0)) bad++;
            if (i < 2000) h1 += int'(ifc.pwm_a); else h2 += int'(ifc.pwm_a);
            if (ifc.done === 1'b1) begin
                msh = a_new;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (ifc.duty_a !== 16'(e.a)) begin failures++; $display("FAIL shadow_duty_a: got %0d expected %0d", ifc.duty_a, e.a); end
                end
            end
            if (i == 300) begin
                ifc.alpha = 512; ifc.beta = 0; ifc.start = 1'b1;
                sb_q.push_back(model(512, 0));
            end
            if (i == 301) ifc.start = 1'b0;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL shadow_trace: got %0d bad cycles expected 0", bad); end
        checks++; if (h1 != 999 || h2 != 1373) begin
            failures++; $display("FAIL shadow_switch: got %0d/%0d expected 999/1373", h1, h2); end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        ifc.alpha = 512; ifc.beta = 0; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            failures++; $display("FAIL midrst_busy: got busy=%b done=%b expected 0/0", ifc.busy, ifc.done); end
        checks++; if (ifc.duty_a !== 16'd500 || ifc.duty_b !== 16'd500 || ifc.duty_c !== 16'd500) begin
            failures++; $display("FAIL midrst_duty: got %0d/%0d/%0d expected 500", ifc.duty_a, ifc.duty_b, ifc.duty_c); end
        @(negedge clk);
        checks++; if (ifc.pwm_sync !== 1'b1) begin failures++; $display("FAIL midrst_sync: got %b expected 1", ifc.pwm_sync); end
        for (int i = 0; i < 10; i++) begin
            if (ifc.done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
    endtask

    initial begin
        rst = 1'b1;
        ifc.alpha = '0;
        ifc.beta  = '0;
        ifc.start = 1'b0;
        test_reset();
        test_zero();
        test_vectors();
        test_overmod();
        test_back_to_back();
        test_shadow_timing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/svpwm_modulator.md
Name: svpwm_modulator

Overview:
- Stage directly downstream of the inverse Park transform in the FOC current loop.
- Consumes alpha/beta voltage commands plus their start strobe and runs an inverse Clarke transform.
- Applies min-max (third-harmonic-equivalent) zero-sequence injection, then scales the result to duty counts.
- Drives three center-aligned PWM outputs from an internal up/down carrier; double-buffered duties take effect only at carrier zero.

Parameters:
- D_WIDTH, 32, signed width of alpha/beta inputs and internal phase voltages
- Q_BITS, 10, fractional bits of fixed-point inputs; 1.0 = 1<<Q_BITS = full modulation (Vdc/2)
- CNT_WIDTH, 16, width of carrier counter and duty values
- PWM_HALF, 1000, carrier peak; PWM period = 2*PWM_HALF clock cycles
- SQRT3_2, 887, round(0.8660254 * 2^Q_BITS), must track Q_BITS

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- alpha  in  D_WIDTH  signed alpha voltage command, Q format
- beta  in  D_WIDTH  signed beta voltage command, Q format
- start  in  1  one-cycle strobe, alpha/beta valid
- busy  out  1  high while computation is in flight
- done  out  1  one-cycle pulse, new duties in shadow registers
- duty_a, duty_b, duty_c  out  CNT_WIDTH  shadow duties, 0..PWM_HALF
- pwm_a, pwm_b, pwm_c  out  1  phase gate commands
- pwm_sync  out  1  one-cycle pulse when carrier == 0

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counter = 0, direction up; shadow and active duties = PWM_HALF/2.
- FSM states: IDLE -> CLARKE -> INJECT -> SCALE -> IDLE. One cycle each. busy = (state != IDLE).
- IDLE: on start=1, register alpha and beta; go to CLARKE. start while busy is ignored, with no queueing.
- CLARKE:
  - va = alpha
  - p = SQRT3_2*beta (2*D_WIDTH bits)
  - vb = (-alpha >>> 1) + (p >>> Q_BITS)
  - vc = (-alpha >>> 1) - (p >>> Q_BITS)
  - All values registered.
- INJECT:
  - off = (max(va,vb,vc) + min(va,vb,vc)) >>> 1
  - vx' = vx - off, registered; arithmetic is sign-extended by one bit to prevent overflow.
- SCALE:
  - h = PWM_HALF/2
  - dx = h + ((vx' * h) >>> Q_BITS), using full-width products and floor (arithmetic-shift) rounding
  - Saturate to [0, PWM_HALF]; write duty_x shadow registers.
  - Pulse done on the cycle after SCALE, coincident with return to IDLE.
  - Latency: start sampled at edge k; done = 1 during cycle k+3 through k+4, i.e. the 3rd edge after acceptance.
- Carrier:
  - Counter free-runs 0 -> PWM_HALF -> 0, up/down, reversing at both ends without dwelling.
  - pwm_sync = (cnt == 0).
- Active duty registers load from shadow when cnt == 0.
  - If a SCALE write and cnt == 0 occur in the same cycle, the old shadow value loads; the new value waits one period.
- Output compare: pwm_x = (cnt < active_x), registered.
  - duty 0 -> constantly low; duty PWM_HALF -> constantly high.
- Reset mid-computation: FSM aborts to IDLE, no done pulse, shadows return to PWM_HALF/2.

Test Plan:
- Reset, then alpha=0, beta=0, start -> done at 3rd edge; duty_a = duty_b = duty_c = 500; pwm duty 50% after next pwm_sync.
- alpha=512, beta=0 -> va=512, vb=vc=-256, off=128; duty_a=687, duty_b=312, duty_c=312.
- alpha=0, beta=1024 -> vb=887, vc=-887, off=0; duty_a=500, duty_b=933, duty_c=66.
- alpha=4096, beta=0 (overmodulation) -> duty_a=1000 (pwm_a constantly high), duty_b=duty_c=0 (constantly low).
- start pulsed again while busy=1 -> ignored, exactly one done. New duty written mid-period -> pwm outputs unchanged until next cnt==0, then switch.
- Assert rst during INJECT -> no done; busy=0 and duties=500 on the next cycle; counter restarts at 0 with pwm_sync high.
